// File: rtl/mvm_result_drain.sv
// Result drain for the matrix-vector multiply core: captures the K words streamed after done,
// buffers them in a FIFO and replays them on a valid/ready stream with a last-of-vector tag.
module mvm_result_drain #(
    parameter int K         = 16,
    parameter int B         = 8,
    parameter int FIRST_LAT = 2,
    parameter int DEPTH     = 32,
    parameter int LOG_DEPTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 done_in,
    input  logic [2*B-1:0]       y_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [2*B-1:0]       m_data,
    output logic                 m_last,
    output logic [LOG_DEPTH:0]   level,
    output logic                 busy,
    output logic                 overflow,
    output logic                 protocol_err
);
    localparam int W  = 2 * B;
    localparam int LW = LOG_DEPTH + 1;
    localparam int IW = $clog2(K + 1);
    localparam int CW = $clog2(FIRST_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, CAP} state_t;

    state_t               state, state_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [CW-1:0]        wcnt, wcnt_nx;
    logic                 push, push_ok, pop, full, last_tag;
    logic [LOG_DEPTH-1:0] rd_ptr, wr_ptr;
    logic [LW-1:0]        cnt;
    logic [W:0]           mem [DEPTH];
    logic [W:0]           head;

    function automatic logic [LOG_DEPTH-1:0] ptr_inc(input logic [LOG_DEPTH-1:0] p);
        return (p == LOG_DEPTH'(DEPTH - 1)) ? '0 : p + LOG_DEPTH'(1);
    endfunction

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        wcnt_nx  = wcnt;
        push     = 1'b0;
        case (state)
            IDLE: begin
                if (done_in) begin
                    if (FIRST_LAT == 1) begin
                        state_nx = CAP;
                        idx_nx   = '0;
                    end else begin
                        state_nx = WAIT;
                        wcnt_nx  = CW'(FIRST_LAT - 1);
                    end
                end
            end
            WAIT: begin
                if (wcnt == CW'(1)) begin
                    state_nx = CAP;
                    idx_nx   = '0;
                end else begin
                    wcnt_nx = wcnt - CW'(1);
                end
            end
            CAP: begin
                push   = 1'b1;
                idx_nx = idx + IW'(1);
                if (idx == IW'(K - 1)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign last_tag = (idx == IW'(K - 1));
    assign full     = (cnt == LW'(DEPTH));
    assign pop      = m_valid & m_ready;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push_ok  = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            wcnt         <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            cnt          <= '0;
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            wcnt  <= wcnt_nx;
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
            if (push && !push_ok)          overflow     <= 1'b1;
            if (done_in && state != IDLE)  protocol_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr] <= {last_tag, y_in};
    end

    assign head    = mem[rd_ptr];
    assign m_valid = (cnt != '0);
    assign m_data  = m_valid ? head[W-1:0] : '0;
    assign m_last  = m_valid & head[W];
    assign level   = cnt;
    assign busy    = (state != IDLE);
endmodule

// File: tb/tb_mvm_result_drain.sv
// Directed bench for mvm_result_drain: an 8-deep instance for most scenarios and a
// 4-deep instance for the overflow case, both sharing the core-side stimulus.
module tb_mvm_result_drain;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        done_in = 1'b0;
    logic [15:0] y_in = '0;

    logic        rdy8 = 1'b0, valid8, last8, busy8, ovf8, perr8;
    logic [15:0] data8;
    logic [3:0]  lvl8;
    logic        rdy4 = 1'b1, valid4, last4, busy4, ovf4, perr4;
    logic [15:0] data4;
    logic [2:0]  lvl4;

    int checks = 0;
    int errors = 0;
    logic [16:0] q8[$];
    logic [16:0] q4[$];

    always #5 clk = ~clk;

    mvm_result_drain #(.K(4), .B(8), .FIRST_LAT(2), .DEPTH(8), .LOG_DEPTH(3)) dut8 (
        .clk(clk), .reset(reset), .done_in(done_in), .y_in(y_in),
        .m_valid(valid8), .m_ready(rdy8), .m_data(data8), .m_last(last8),
        .level(lvl8), .busy(busy8), .overflow(ovf8), .protocol_err(perr8));

    mvm_result_drain #(.K(4), .B(8), .FIRST_LAT(2), .DEPTH(4), .LOG_DEPTH(2)) dut4 (
        .clk(clk), .reset(reset), .done_in(done_in), .y_in(y_in),
        .m_valid(valid4), .m_ready(rdy4), .m_data(data4), .m_last(last4),
        .level(lvl4), .busy(busy4), .overflow(ovf4), .protocol_err(perr4));

    // Record every word handed over at a clock edge.
    always @(posedge clk) begin
        if (!reset) begin
            if (valid8 && rdy8) q8.push_back({last8, data8});
            if (valid4 && rdy4) q4.push_back({last4, data4});
        end
    end

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; done_in = 1'b0; y_in = '0;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
    endtask

    // done pulse then words on the cycles the core would present them.
    task automatic capture(input logic [15:0] w[4], input bit ready_during);
        @(negedge clk); done_in = 1'b1;
        @(negedge clk); done_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); y_in = w[i];
            if (i == 0 && ready_during) rdy8 = 1'b1;
        end
        @(negedge clk); y_in = '0;
        if (ready_during) rdy8 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid8); end
        checks++; if (data8 !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0", data8); end
        checks++; if (last8 !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", last8); end
        checks++; if (lvl8 !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", lvl8); end
        checks++; if ({busy8, ovf8, perr8} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy8, ovf8, perr8}); end
    endtask

    task automatic test_basic();
        logic [15:0] v[4] = '{16'd10, 16'hFFFD, 16'd7, 16'd2};
        do_reset(); rdy8 = 1'b1; q8.delete();
        capture(v, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (q8.size() !== 4) begin errors++; $display("FAIL basic_count got %0d want 4", q8.size()); end
        for (int i = 0; i < 4 && i < q8.size(); i++) begin
            checks++; if (q8[i] !== {(i == 3), v[i]}) begin errors++; $display("FAIL basic_word%0d got %h want %h", i, q8[i], {(i == 3), v[i]}); end
        end
        checks++; if (lvl8 !== 4'd0) begin errors++; $display("FAIL basic_level got %0d want 0", lvl8); end
        checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL basic_overflow got %b want 0", ovf8); end
    endtask

    task automatic test_backpressure();
        logic [15:0] a[4] = '{16'd1, 16'd2, 16'd3, 16'd4};
        logic [15:0] b[4] = '{16'd5, 16'd6, 16'd7, 16'd8};
        do_reset(); rdy8 = 1'b0; q8.delete();
        capture(a, 1'b0);
        capture(b, 1'b0);
        checks++; if (lvl8 !== 4'd8) begin errors++; $display("FAIL bp_level_full got %0d want 8", lvl8); end
        checks++; if (data8 !== 16'd1 || valid8 !== 1'b1) begin errors++; $display("FAIL bp_head got %0d/%b want 1/1", data8, valid8); end
        repeat (2) @(negedge clk);
        checks++; if (data8 !== 16'd1 || last8 !== 1'b0) begin errors++; $display("FAIL bp_hold got %0d/%b want 1/0", data8, last8); end
        rdy8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++; if (lvl8 !== 4'(8 - k)) begin errors++; $display("FAIL bp_drain%0d level got %0d want %0d", k, lvl8, 8 - k); end
        end
        checks++; if (q8.size() !== 8) begin errors++; $display("FAIL bp_count got %0d want 8", q8.size()); end
        for (int i = 0; i < 8 && i < q8.size(); i++) begin
            checks++; if (q8[i] !== {(i == 3 || i == 7), 16'(i + 1)}) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, q8[i], {(i == 3 || i == 7), 16'(i + 1)}); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] a[4] = '{16'd11, 16'd12, 16'd13, 16'd14};
        logic [15:0] b[4] = '{16'd15, 16'd16, 16'd17, 16'd18};
        do_reset(); rdy8 = 1'b1; rdy4 = 1'b0; q4.delete();
        capture(a, 1'b0);
        capture(b, 1'b0);
        checks++; if (lvl4 !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", lvl4); end
        checks++; if (ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf4); end
        checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL ovf_flag_deep got %b want 0", ovf8); end
        rdy4 = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (q4.size() !== 4) begin errors++; $display("FAIL ovf_count got %0d want 4", q4.size()); end
        for (int i = 0; i < 4 && i < q4.size(); i++) begin
            checks++; if (q4[i] !== {(i == 3), a[i]}) begin errors++; $display("FAIL ovf_word%0d got %h want %h", i, q4[i], {(i == 3), a[i]}); end
        end
        checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", valid4); end
    endtask

    task automatic test_full_simultaneous();
        logic [15:0] a[4] = '{16'd1, 16'd2, 16'd3, 16'd4};
        logic [15:0] b[4] = '{16'd5, 16'd6, 16'd7, 16'd8};
        logic [15:0] c[4] = '{16'd9, 16'd10, 16'd11, 16'd12};
        do_reset(); rdy8 = 1'b0; q8.delete();
        capture(a, 1'b0);
        capture(b, 1'b0);
        capture(c, 1'b1);
        checks++; if (lvl8 !== 4'd8) begin errors++; $display("FAIL full_sim_level got %0d want 8", lvl8); end
        checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL full_sim_overflow got %b want 0", ovf8); end
        checks++; if (data8 !== 16'd5) begin errors++; $display("FAIL full_sim_head got %0d want 5", data8); end
        rdy8 = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (q8.size() !== 12) begin errors++; $display("FAIL full_sim_count got %0d want 12", q8.size()); end
        for (int i = 0; i < 12 && i < q8.size(); i++) begin
            checks++; if (q8[i] !== {(i % 4 == 3), 16'(i + 1)}) begin errors++; $display("FAIL full_sim_word%0d got %h want %h", i, q8[i], {(i % 4 == 3), 16'(i + 1)}); end
        end
    endtask

    task automatic test_protocol_err();
        logic [15:0] v[4] = '{16'h8000, 16'h7FFF, 16'hFF00, 16'h0001};
        do_reset(); rdy8 = 1'b1; q8.delete();
        @(negedge clk); done_in = 1'b1;
        @(negedge clk); done_in = 1'b0;
        @(negedge clk); y_in = v[0];
        @(negedge clk); y_in = v[1]; done_in = 1'b1;
        @(negedge clk); y_in = v[2]; done_in = 1'b0;
        checks++; if (perr8 !== 1'b1) begin errors++; $display("FAIL perr_flag got %b want 1", perr8); end
        @(negedge clk); y_in = v[3];
        @(negedge clk); y_in = '0;
        repeat (6) @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL perr_busy got %b want 0", busy8); end
        checks++; if (q8.size() !== 4) begin errors++; $display("FAIL perr_count got %0d want 4", q8.size()); end
        for (int i = 0; i < 4 && i < q8.size(); i++) begin
            checks++; if (q8[i] !== {(i == 3), v[i]}) begin errors++; $display("FAIL perr_word%0d got %h want %h", i, q8[i], {(i == 3), v[i]}); end
        end
    endtask

    task automatic test_reset_midcapture();
        logic [15:0] w[4] = '{16'd100, 16'd101, 16'd102, 16'd103};
        logic [15:0] d[4] = '{16'd21, 16'hFFEA, 16'd23, 16'hFFE8};
        rdy8 = 1'b0; q8.delete();
        @(negedge clk); done_in = 1'b1;
        @(negedge clk); done_in = 1'b0;
        @(negedge clk); y_in = w[0];
        @(negedge clk); y_in = w[1];
        @(negedge clk);
        checks++; if (lvl8 !== 4'd2 || busy8 !== 1'b1) begin errors++; $display("FAIL mid_pre got level %0d busy %b want 2/1", lvl8, busy8); end
        reset = 1'b1; y_in = w[2];
        @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy8); end
        checks++; if (lvl8 !== 4'd0 || valid8 !== 1'b0) begin errors++; $display("FAIL mid_empty got %0d/%b want 0/0", lvl8, valid8); end
        checks++; if ({ovf8, perr8} !== 2'b00) begin errors++; $display("FAIL mid_flags got %b want 00", {ovf8, perr8}); end
        reset = 1'b0; y_in = '0;
        capture(d, 1'b0);
        checks++; if (lvl8 !== 4'd4 || data8 !== 16'd21) begin errors++; $display("FAIL mid_recap got %0d/%0d want 4/21", lvl8, data8); end
        rdy8 = 1'b1; q8.delete();
        repeat (6) @(negedge clk);
        checks++; if (q8.size() !== 4) begin errors++; $display("FAIL mid_count got %0d want 4", q8.size()); end
        for (int i = 0; i < 4 && i < q8.size(); i++) begin
            checks++; if (q8[i] !== {(i == 3), d[i]}) begin errors++; $display("FAIL mid_word%0d got %h want %h", i, q8[i], {(i == 3), d[i]}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_full_simultaneous();
        test_protocol_err();
        test_reset_midcapture();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
